// File: rtl/alu_pkg.sv
// Shared ALU operation encodings and RV32I opcode/funct3 constants.
package alu_pkg;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluAnd   = 4'd2;
    localparam logic [3:0] AluOr    = 4'd3;
    localparam logic [3:0] AluXor   = 4'd4;
    localparam logic [3:0] AluSll   = 4'd5;
    localparam logic [3:0] AluSrl   = 4'd6;
    localparam logic [3:0] AluSra   = 4'd7;
    localparam logic [3:0] AluSlt   = 4'd8;
    localparam logic [3:0] AluSltu  = 4'd9;
    localparam logic [3:0] AluCopyB = 4'd10;
    localparam logic [3:0] AluXxx   = 4'd15;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3Srl    = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;

endpackage

// File: rtl/alu_core.sv
// 32-bit operand datapath: computes the result for a decoded ALU operation.
module alu_core
    import alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  alu_op_i,
    output logic [31:0] out_o
);

    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    always_comb begin
        out_o = 32'h0;
        case (alu_op_i)
            AluAdd:   out_o = a_i + b_i;
            AluSub:   out_o = a_i - b_i;
            AluAnd:   out_o = a_i & b_i;
            AluOr:    out_o = a_i | b_i;
            AluXor:   out_o = a_i ^ b_i;
            AluSll:   out_o = a_i << shamt;
            AluSrl:   out_o = a_i >> shamt;
            AluSra:   out_o = $unsigned($signed(a_i) >>> shamt);
            AluSlt:   out_o = {31'b0, $signed(a_i) < $signed(b_i)};
            AluSltu:  out_o = {31'b0, a_i < b_i};
            AluCopyB: out_o = b_i;
            default:  out_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/alu_dec.sv
// RV32I ALU decoder plus datapath with an optional output register.
// Define ALU_OUT_REG_EN to register Out into Out_q; otherwise Out_q = Out.
module alu_dec
    import alu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct,
    input  logic        add_rshift_type,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [3:0]  ALUop,
    output logic [31:0] Out,
    output logic [31:0] Out_q
);

    logic [3:0] arith_op;

    // Shared funct3 decode; sub_ok distinguishes R-type from I-type at funct 000.
    function automatic logic [3:0] dec_funct(input logic [2:0] f, input logic alt,
                                             input logic sub_ok);
        logic [3:0] op;
        op = AluXxx;
        case (f)
            F3AddSub: op = (alt && sub_ok) ? AluSub : AluAdd;
            F3Sll:    op = AluSll;
            F3Slt:    op = AluSlt;
            F3Sltu:   op = AluSltu;
            F3Xor:    op = AluXor;
            F3Srl:    op = alt ? AluSra : AluSrl;
            F3Or:     op = AluOr;
            F3And:    op = AluAnd;
            default:  op = AluXxx;
        endcase
        return op;
    endfunction

    always_comb begin
        arith_op = AluXxx;
        case (opcode)
            OpLui:    arith_op = AluCopyB;
            OpAuipc,
            OpBranch,
            OpLoad,
            OpStore,
            OpJal,
            OpJalr:   arith_op = AluAdd;
            OpRType:  arith_op = dec_funct(funct, add_rshift_type, 1'b1);
            OpIType:  arith_op = dec_funct(funct, add_rshift_type, 1'b0);
            default:  arith_op = AluXxx;
        endcase
    end

    assign ALUop = arith_op;

    alu_core u_alu_core (
        .a_i      (A),
        .b_i      (B),
        .alu_op_i (arith_op),
        .out_o    (Out)
    );

`ifdef ALU_OUT_REG_EN
    logic [31:0] out_d, out_q;

    assign out_d = Out;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            out_q <= 32'h0;
        end else begin
            out_q <= out_d;
        end
    end

    assign Out_q = out_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = Clock ^ Reset_n;

    assign Out_q = Out;
`endif

endmodule

// File: tb/tb_alu_dec.sv
// Directed table-driven bench for alu_dec, plus reset/register sequences.
module tb_alu_dec;
    import alu_pkg::*;

    logic        Clock;
    logic        Reset_n;
    logic [6:0]  opcode;
    logic [2:0]  funct;
    logic        add_rshift_type;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUop;
    logic [31:0] Out;
    logic [31:0] Out_q;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [6:0]  opcode;
        logic [2:0]  funct;
        logic        ars;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_op;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    alu_dec dut (
        .Clock           (Clock),
        .Reset_n         (Reset_n),
        .opcode          (opcode),
        .funct           (funct),
        .add_rshift_type (add_rshift_type),
        .A               (A),
        .B               (B),
        .ALUop           (ALUop),
        .Out             (Out),
        .Out_q           (Out_q)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [6:0] op, input logic [2:0] f,
                                input logic ars, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] eop, input logic [31:0] eout);
        vec_t v;
        v.name = name; v.opcode = op; v.funct = f; v.ars = ars;
        v.a = a; v.b = b; v.exp_op = eop; v.exp_out = eout;
        return v;
    endfunction

    initial begin
        logic [2:0] rf;
        logic       ra;

        // Non-ALU opcodes with random funct/add_rshift_type
        rf = 3'($urandom_range(0, 7)); ra = 1'($urandom_range(0, 1));
        vecs.push_back(mk("lui", OpLui, rf, ra, 32'h80000005, 32'hFFFF8003, AluCopyB,
                          32'hFFFF8003));
        rf = 3'($urandom_range(0, 7)); ra = 1'($urandom_range(0, 1));
        vecs.push_back(mk("auipc", OpAuipc, rf, ra, 32'h80000005, 32'hFFFF8003, AluAdd,
                          32'h7FFF8008));
        rf = 3'($urandom_range(0, 7)); ra = 1'($urandom_range(0, 1));
        vecs.push_back(mk("load", OpLoad, rf, ra, 32'h80000005, 32'hFFFF8003, AluAdd,
                          32'h7FFF8008));
        rf = 3'($urandom_range(0, 7)); ra = 1'($urandom_range(0, 1));
        vecs.push_back(mk("store", OpStore, rf, ra, 32'h80000005, 32'hFFFF8003, AluAdd,
                          32'h7FFF8008));
        rf = 3'($urandom_range(0, 7)); ra = 1'($urandom_range(0, 1));
        vecs.push_back(mk("branch", OpBranch, rf, ra, 32'h80000005, 32'hFFFF8003, AluAdd,
                          32'h7FFF8008));
        vecs.push_back(mk("jal", OpJal, 3'b101, 1'b1, 32'h80000005, 32'hFFFF8003, AluAdd,
                          32'h7FFF8008));
        vecs.push_back(mk("jalr", OpJalr, 3'b011, 1'b1, 32'h80000005, 32'hFFFF8003, AluAdd,
                          32'h7FFF8008));
        // Arithmetic
        vecs.push_back(mk("r_add", OpRType, 3'b000, 1'b0, 32'h5, 32'h7, AluAdd, 32'hC));
        vecs.push_back(mk("r_sub", OpRType, 3'b000, 1'b1, 32'h5, 32'h7, AluSub, 32'hFFFFFFFE));
        vecs.push_back(mk("i_add_alt", OpIType, 3'b000, 1'b1, 32'h5, 32'h7, AluAdd, 32'hC));
        // Logic
        vecs.push_back(mk("r_and", OpRType, 3'b111, 1'b0, 32'hFFFF, 32'hE5C1, AluAnd, 32'hE5C1));
        vecs.push_back(mk("r_or", OpRType, 3'b110, 1'b0, 32'hFFFF, 32'hE5C1, AluOr, 32'hFFFF));
        vecs.push_back(mk("r_xor", OpRType, 3'b100, 1'b0, 32'hFFFF, 32'hE5C1, AluXor, 32'h1A3E));
        vecs.push_back(mk("i_xor", OpIType, 3'b100, 1'b1, 32'hFFFF, 32'hE5C1, AluXor, 32'h1A3E));
        // Shifts: only B[4:0]=4 counts
        vecs.push_back(mk("r_sll", OpRType, 3'b001, 1'b0, 32'h80000000, 32'h24, AluSll, 32'h0));
        vecs.push_back(mk("r_srl", OpRType, 3'b101, 1'b0, 32'h80000000, 32'h24, AluSrl,
                          32'h08000000));
        vecs.push_back(mk("r_sra", OpRType, 3'b101, 1'b1, 32'h80000000, 32'h24, AluSra,
                          32'hF8000000));
        vecs.push_back(mk("i_sra", OpIType, 3'b101, 1'b1, 32'h80000000, 32'h24, AluSra,
                          32'hF8000000));
        vecs.push_back(mk("i_sll1", OpIType, 3'b001, 1'b0, 32'h00000003, 32'h1, AluSll,
                          32'h00000006));
        // Compares
        vecs.push_back(mk("r_slt", OpRType, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h1, AluSlt, 32'h1));
        vecs.push_back(mk("r_sltu", OpRType, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h1, AluSltu, 32'h0));
        vecs.push_back(mk("i_sltu_lt", OpIType, 3'b011, 1'b0, 32'h1, 32'hFFFFFFFF, AluSltu,
                          32'h1));
        vecs.push_back(mk("i_slt_ge", OpIType, 3'b010, 1'b0, 32'h1, 32'hFFFFFFFF, AluSlt, 32'h0));
        // Illegal opcode
        vecs.push_back(mk("illegal", 7'b1111111, 3'b000, 1'b0, 32'h12345678, 32'h9, AluXxx,
                          32'h0));
    end

    initial begin
        Reset_n = 1'b0;
        opcode = OpRType; funct = 3'b000; add_rshift_type = 1'b0;
        A = 32'h5; B = 32'h7;
        #2;
        // Out and ALUop are combinational and ignore reset
        check("rst_aluop", {28'b0, ALUop}, {28'b0, AluAdd});
        check("rst_out", Out, 32'hC);
`ifdef ALU_OUT_REG_EN
        check("rst_out_q", Out_q, 32'h0);
`else
        check("rst_out_q", Out_q, 32'hC);
`endif
        @(negedge Clock);
        Reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge Clock);
            opcode = vecs[i].opcode; funct = vecs[i].funct;
            add_rshift_type = vecs[i].ars; A = vecs[i].a; B = vecs[i].b;
            #1;
            check({vecs[i].name, "_aluop"}, {28'b0, ALUop}, {28'b0, vecs[i].exp_op});
            check({vecs[i].name, "_out"}, Out, vecs[i].exp_out);
            @(posedge Clock);
            #1;
            check({vecs[i].name, "_out_q"}, Out_q, vecs[i].exp_out);
        end

        // Register latency and asynchronous clear
        @(negedge Clock);
        opcode = OpRType; funct = 3'b000; add_rshift_type = 1'b0; A = 32'h10; B = 32'h20;
        @(posedge Clock); #1;
        check("seq_load", Out_q, 32'h30);
        A = 32'h100;
        #1;
        check("seq_out_now", Out, 32'h120);
`ifdef ALU_OUT_REG_EN
        check("seq_hold", Out_q, 32'h30);
`else
        check("seq_hold", Out_q, 32'h120);
`endif
        @(posedge Clock); #1;
        check("seq_next", Out_q, 32'h120);
        #1;
        Reset_n = 1'b0;
        #1;
`ifdef ALU_OUT_REG_EN
        check("async_clr", Out_q, 32'h0);
`else
        check("async_clr", Out_q, 32'h120);
`endif
        check("rst_out_live", Out, 32'h120);
        @(posedge Clock); #1;
`ifdef ALU_OUT_REG_EN
        check("rst_held", Out_q, 32'h0);
`else
        check("rst_held", Out_q, 32'h120);
`endif
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock); #1;
        check("post_rst_load", Out_q, 32'h120);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_dec.md
ALU_DEC -- requirements
Module: alu_dec

Interface
REQ-001 SHALL have no parameters; data width fixed at 32 bits, ALUop width fixed at 4 bits.
REQ-002 SHALL have port Clock, input, 1 bit: single clock; rising edge active.
REQ-003 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port opcode, input, 7 bits: RV32I instruction opcode.
REQ-005 SHALL have port funct, input, 3 bits: instruction funct3.
REQ-006 SHALL have port add_rshift_type, input, 1 bit: instruction bit 30; selects SUB over ADD and SRA over SRL.
REQ-007 SHALL have ports A and B, input, 32 bits each: operands.
REQ-008 SHALL have port ALUop, output, 4 bits: decoded operation.
REQ-009 SHALL have port Out, output, 32 bits: combinational result.
REQ-010 SHALL have port Out_q, output, 32 bits: result after the configured register stage.

Function
REQ-011 SHALL encode ALUop as: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, COPY_B=10, XXX=15.
REQ-012 SHALL decode opcode 0110111 (LUI) to COPY_B, ignoring funct and add_rshift_type.
REQ-013 SHALL decode AUIPC 0010111, BRANCH 1100011, LOAD 0000011, STORE 0100011, JAL 1101111 and JALR 1100111 to ADD, ignoring funct and add_rshift_type.
REQ-014 SHALL decode R-type 0110011 by funct: 000 gives ADD, or SUB when add_rshift_type=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 gives SRL, or SRA when add_rshift_type=1; 110 OR; 111 AND.
REQ-015 SHALL decode I-type 0010011 identically to R-type, except funct 000 is always ADD regardless of add_rshift_type.
REQ-016 SHALL decode any other opcode to XXX.
REQ-017 SHALL compute Out combinationally from A, B and ALUop, with zero cycles of latency from any input change.
REQ-018 SHALL make ADD and SUB modulo 2^32, with carry and overflow discarded.
REQ-019 SHALL make all shift amounts B[4:0]; SRA replicates A[31].
REQ-020 SHALL make SLT a signed compare of A and B, and SLTU an unsigned compare; the result is 32'h1 if A<B, else 32'h0.
REQ-021 SHALL make COPY_B output B, and XXX output 32'h0.

Reset
REQ-022 SHALL clear Out_q to 32'h0 immediately on assertion of Reset_n=0, independent of Clock, whenever the register stage is compiled in.
REQ-023 SHALL hold Out_q at 0 while Reset_n is low, and load on the first rising Clock edge after deassertion.
REQ-024 SHALL leave ALUop and Out unaffected by reset; both are purely combinational.

Configuration
REQ-025 SHALL control the register stage with macro ALU_OUT_REG_EN.
REQ-026 SHALL, when ALU_OUT_REG_EN is defined, register Out into Out_q on every rising Clock edge, giving 1-cycle latency.
REQ-027 SHALL, when ALU_OUT_REG_EN is undefined, drive Out_q = Out combinationally; Clock and Reset_n are then unused.

Structure
REQ-028 SHALL place the ALUop localparams and RV32I opcode/funct3 constants in shared package alu_pkg.
REQ-029 SHALL implement the operand datapath as sub-module alu_core (A, B, ALUop -> Out); alu_dec holds the decoder, the sub-module instance and the optional register.

Verification
REQ-030 SHALL cover a LUI/AUIPC/LOAD/STORE/BRANCH sweep with random funct/add_rshift_type and A=32'h80000005, B=32'hFFFF8003 -> Out=B for LUI, 32'h7FFF8008 for the others.
REQ-031 SHALL cover R-type arithmetic: A=32'h5, B=32'h7, ADD -> 32'hC; same operands with add_rshift_type=1 -> 32'hFFFFFFFE; I-type funct 000 with add_rshift_type=1 -> 32'hC.
REQ-032 SHALL cover logic ops with A=32'hFFFF, B=32'hE5C1: AND -> 32'hE5C1, OR -> 32'hFFFF, XOR -> 32'h1A3E.
REQ-033 SHALL cover shifts: A=32'h80000000, B=32'h24; SLL -> 32'h0; SRL -> 32'h08000000; SRA -> 32'hF8000000 (shift amount 4).
REQ-034 SHALL cover compares: A=32'hFFFFFFFF, B=32'h1; SLT -> 32'h1; SLTU -> 32'h0. Also opcode 1111111 -> ALUop=15, Out=0.
REQ-035 SHALL cover, with ALU_OUT_REG_EN defined: Out_q equals the previous cycle's Out; Reset_n pulsed low mid-cycle clears Out_q to 0 at once, with no Clock edge needed.
